// File: rtl/cdc_handshake_tx.sv
// cdc_handshake_tx: serialises a Gray-coded payload behind a marker bit to a
// receiver in another clock domain, then waits for the receiver's completion
// flag (synchronised locally) or gives up after a bounded number of cycles.
module cdc_handshake_tx #(
    parameter int DATA_W      = 8,
    parameter int SYNC_STAGES = 2,
    parameter int ACK_TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic              a_gray_data,
    output logic              a_clk_en,
    input  logic              b_done,
    output logic              busy,
    output logic              timeout_err
);

    localparam int CW = $clog2(ACK_TIMEOUT + 1);
    localparam int BW = $clog2(DATA_W + 1);
    localparam logic [CW-1:0] TIMEOUT_VAL = CW'(ACK_TIMEOUT);
    localparam logic [BW-1:0] LAST_BIT    = BW'(DATA_W);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        SEND     = 2'd1,
        WAIT_ACK = 2'd2
    } state_t;

    state_t            state_reg, state_next;
    logic [DATA_W:0]   shift_reg, shift_next;
    logic [BW-1:0]     bit_cnt_reg, bit_cnt_next;
    logic [CW-1:0]     count_reg, count_next, count_inc;
    logic              seen_low_reg, seen_low_next;
    logic              gray_data_reg, gray_data_next;
    logic              clk_en_reg, clk_en_next;
    logic              timeout_reg, timeout_next;
    logic [SYNC_STAGES-1:0] sync_reg;
    logic              b_done_s;
    logic              accept;
    logic [DATA_W-1:0] gray;

    assign in_ready    = (state_reg == IDLE) && !reset;
    assign accept      = in_valid && in_ready;
    assign busy        = (state_reg != IDLE);
    assign gray        = in_data ^ (in_data >> 1);
    assign a_gray_data = gray_data_reg;
    assign a_clk_en    = clk_en_reg;
    assign timeout_err = timeout_reg;
    assign b_done_s    = sync_reg[SYNC_STAGES-1];

    // Synchroniser chain for the receiver's completion flag; idles high.
    genvar gi;
    generate
        for (gi = 0; gi < SYNC_STAGES; gi++) begin : g_sync
            if (gi == 0) begin : g_first
                // First stage samples the asynchronous flag.
                always_ff @(posedge clk or posedge reset) begin
                    if (reset) sync_reg[gi] <= 1'b1;
                    else       sync_reg[gi] <= b_done;
                end
            end else begin : g_rest
                // Later stages let any metastability settle.
                always_ff @(posedge clk or posedge reset) begin
                    if (reset) sync_reg[gi] <= 1'b1;
                    else       sync_reg[gi] <= sync_reg[gi-1];
                end
            end
        end
    endgenerate

    // Next-state, datapath and registered-output decisions.
    always_comb begin
        state_next     = state_reg;
        shift_next     = shift_reg;
        bit_cnt_next   = '0;
        count_next     = '0;
        seen_low_next  = seen_low_reg;
        gray_data_next = 1'b0;
        clk_en_next    = 1'b1;
        timeout_next   = 1'b0;
        // Saturating increment: the counter can never wrap back to zero.
        count_inc = (count_reg == TIMEOUT_VAL) ? count_reg : count_reg + 1'b1;

        case (state_reg)
            IDLE: begin
                if (accept) begin
                    state_next     = SEND;
                    shift_next     = {1'b1, gray};
                    seen_low_next  = 1'b0;
                    clk_en_next    = 1'b0;
                    gray_data_next = 1'b1;
                end
            end
            SEND: begin
                if (!b_done_s) seen_low_next = 1'b1;
                if (bit_cnt_reg == LAST_BIT) begin
                    state_next = WAIT_ACK;
                end else begin
                    bit_cnt_next   = bit_cnt_reg + 1'b1;
                    // Rotate rather than zero-fill; the word is dead after the frame.
                    shift_next     = {shift_reg[DATA_W-1:0], shift_reg[DATA_W]};
                    clk_en_next    = 1'b0;
                    gray_data_next = shift_reg[DATA_W-1];
                end
            end
            WAIT_ACK: begin
                if (!b_done_s) seen_low_next = 1'b1;
                // A high flag only counts once it has been seen low for this frame,
                // so a stale completion from the previous frame is not taken as ack.
                if (b_done_s && seen_low_reg) begin
                    state_next = IDLE;
                end else if (count_inc == TIMEOUT_VAL) begin
                    state_next   = IDLE;
                    timeout_next = 1'b1;
                end else begin
                    count_next = count_inc;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_reg <= IDLE;
        else       state_reg <= state_next;
    end

    // Datapath and output flops; reset aborts any frame in flight.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            shift_reg     <= '0;
            bit_cnt_reg   <= '0;
            count_reg     <= '0;
            seen_low_reg  <= 1'b0;
            gray_data_reg <= 1'b0;
            clk_en_reg    <= 1'b1;
            timeout_reg   <= 1'b0;
        end else begin
            shift_reg     <= shift_next;
            bit_cnt_reg   <= bit_cnt_next;
            count_reg     <= count_next;
            seen_low_reg  <= seen_low_next;
            gray_data_reg <= gray_data_next;
            clk_en_reg    <= clk_en_next;
            timeout_reg   <= timeout_next;
        end
    end

endmodule

// File: tb/tb_cdc_handshake_tx.sv
// Self-checking bench for cdc_handshake_tx: frames, ack latency, timeout,
// mid-frame reset and back-to-back transfers against a behavioural model.
module tb_cdc_handshake_tx;

    localparam int DW = 8;
    localparam int SS = 2;
    localparam int TO = 12;

    logic          clk = 1'b0;
    logic          reset;
    logic          in_valid;
    logic [DW-1:0] in_data;
    logic          in_ready;
    logic          a_gray_data;
    logic          a_clk_en;
    logic          b_done;
    logic          busy;
    logic          timeout_err;

    int errors = 0;
    int checks = 0;

    cdc_handshake_tx #(
        .DATA_W(DW),
        .SYNC_STAGES(SS),
        .ACK_TIMEOUT(TO)
    ) dut (
        .clk(clk),
        .reset(reset),
        .in_valid(in_valid),
        .in_data(in_data),
        .in_ready(in_ready),
        .a_gray_data(a_gray_data),
        .a_clk_en(a_clk_en),
        .b_done(b_done),
        .busy(busy),
        .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    // Expected frame: marker then Gray bits, bit DW sent first.
    function automatic logic [DW:0] frame_bits(input logic [DW-1:0] d);
        logic [DW:0] f;
        logic [DW:0] ext;
        ext = {1'b0, d};
        f[DW] = 1'b1;
        for (int i = 0; i < DW; i++) f[i] = ext[i] ^ ext[i+1];
        return f;
    endfunction

    // One full transaction from IDLE. drop_low: receiver drops b_done at accept;
    // ack_at: WAIT_ACK cycle on which b_done rises (0 = never).
    task automatic run_frame(input logic [DW-1:0] d, input bit drop_low,
                             input int ack_at, input bit scramble);
        logic [DW:0] exp;
        bit acked;
        int done_cyc;
        exp = frame_bits(d);
        acked = drop_low && (ack_at > 0) && (ack_at + SS <= TO);
        done_cyc = acked ? ack_at + SS : TO;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL pre_ready got=%b exp=1", in_ready); end
        in_valid = 1'b1;
        in_data = d;
        b_done = drop_low ? 1'b0 : 1'b1;
        @(negedge clk);
        for (int k = 0; k <= DW; k++) begin
            if (scramble) begin
                in_valid = 1'($urandom_range(0, 1));
                in_data = DW'($urandom);
            end else begin
                in_valid = 1'b0;
            end
            checks++; if (a_clk_en !== 1'b0) begin errors++; $display("FAIL frame_en bit=%0d got=%b exp=0", k, a_clk_en); end
            checks++; if (a_gray_data !== exp[DW-k]) begin errors++; $display("FAIL frame_bit data=%h bit=%0d got=%b exp=%b", d, k, a_gray_data, exp[DW-k]); end
            checks++; if (busy !== 1'b1) begin errors++; $display("FAIL frame_busy bit=%0d got=%b exp=1", k, busy); end
            @(negedge clk);
        end
        for (int w = 1; w <= done_cyc; w++) begin
            if (drop_low && w == ack_at) b_done = 1'b1;
            in_valid = (scramble && w != done_cyc) ? 1'($urandom_range(0, 1)) : 1'b0;
            if (scramble) in_data = DW'($urandom);
            checks++; if (busy !== 1'b1) begin errors++; $display("FAIL wait_busy cyc=%0d got=%b exp=1", w, busy); end
            checks++; if (a_clk_en !== 1'b1 || a_gray_data !== 1'b0) begin errors++; $display("FAIL wait_idle_line cyc=%0d got en=%b data=%b exp en=1 data=0", w, a_clk_en, a_gray_data); end
            checks++; if (timeout_err !== 1'b0) begin errors++; $display("FAIL wait_timeout cyc=%0d got=%b exp=0", w, timeout_err); end
            @(negedge clk);
        end
        checks++; if (busy !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("FAIL done_state got busy=%b ready=%b exp busy=0 ready=1", busy, in_ready); end
        checks++; if (timeout_err !== !acked) begin errors++; $display("FAIL done_timeout got=%b exp=%b", timeout_err, !acked); end
        checks++; if (a_clk_en !== 1'b1) begin errors++; $display("FAIL done_en got=%b exp=1", a_clk_en); end
        @(negedge clk);
        checks++; if (timeout_err !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL after_done got terr=%b busy=%b exp terr=0 busy=0", timeout_err, busy); end
        b_done = 1'b1;
        $display("frame data=%h gray=%h ack_at=%0d outcome=%s", d, exp[DW-1:0], ack_at, acked ? "ack" : "timeout");
    endtask

    task automatic test_reset();
        reset = 1'b1;
        in_valid = 1'b0;
        in_data = '0;
        b_done = 1'b1;
        repeat (3) @(negedge clk);
        checks++; if (in_ready !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL reset_ready_busy got ready=%b busy=%b exp 0 0", in_ready, busy); end
        checks++; if (a_clk_en !== 1'b1 || a_gray_data !== 1'b0) begin errors++; $display("FAIL reset_line got en=%b data=%b exp en=1 data=0", a_clk_en, a_gray_data); end
        checks++; if (timeout_err !== 1'b0) begin errors++; $display("FAIL reset_timeout got=%b exp=0", timeout_err); end
        reset = 1'b0;
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL release_ready got=%b exp=1", in_ready); end
        $display("reset released");
    endtask

    task automatic test_basic();
        run_frame(8'h5A, 1'b1, 1, 1'b0);
    endtask

    task automatic test_ack_latency();
        run_frame(DW'($urandom), 1'b1, 3, 1'b0);
        run_frame(DW'($urandom), 1'b1, 5, 1'b1);
    endtask

    task automatic test_stuck_high();
        run_frame(DW'($urandom), 1'b0, 0, 1'b0);
        run_frame(DW'($urandom), 1'b0, 2, 1'b1);
    endtask

    task automatic test_boundary();
        run_frame(DW'($urandom), 1'b1, TO - SS, 1'b1);
        run_frame(DW'($urandom), 1'b1, TO - SS + 1, 1'b0);
    endtask

    task automatic test_mid_reset();
        @(negedge clk);
        in_valid = 1'b1;
        in_data = DW'($urandom);
        b_done = 1'b0;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (a_clk_en !== 1'b0) begin errors++; $display("FAIL midrst_sending got=%b exp=0", a_clk_en); end
        reset = 1'b1;
        #1;
        checks++; if (a_clk_en !== 1'b1 || a_gray_data !== 1'b0) begin errors++; $display("FAIL midrst_line got en=%b data=%b exp en=1 data=0", a_clk_en, a_gray_data); end
        checks++; if (busy !== 1'b0 || in_ready !== 1'b0 || timeout_err !== 1'b0) begin errors++; $display("FAIL midrst_flags got busy=%b ready=%b terr=%b exp 0 0 0", busy, in_ready, timeout_err); end
        @(negedge clk);
        reset = 1'b0;
        b_done = 1'b1;
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL midrst_release got=%b exp=1", in_ready); end
        @(negedge clk);
        checks++; if (a_clk_en !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL midrst_no_resume got en=%b busy=%b exp en=1 busy=0", a_clk_en, busy); end
        $display("mid-frame reset applied");
        run_frame(8'h00, 1'b1, 1, 1'b0);
    endtask

    task automatic test_back_to_back();
        logic [DW-1:0] d;
        logic [DW:0] exp;
        in_valid = 1'b1;
        in_data = 8'hFF;
        b_done = 1'b0;
        @(negedge clk);
        for (int f = 0; f < 2; f++) begin
            d = (f == 0) ? 8'hFF : 8'h01;
            exp = frame_bits(d);
            for (int k = 0; k <= DW; k++) begin
                if (k == 0) begin
                    in_data = (f == 0) ? 8'h01 : DW'($urandom);
                    in_valid = (f == 0);
                end
                checks++; if (a_clk_en !== 1'b0 || a_gray_data !== exp[DW-k]) begin errors++; $display("FAIL b2b_bit frame=%0d bit=%0d got en=%b data=%b exp en=0 data=%b", f, k, a_clk_en, a_gray_data, exp[DW-k]); end
                @(negedge clk);
            end
            for (int w = 1; w <= SS + 1; w++) begin
                if (w == 1) b_done = 1'b1;
                checks++; if (busy !== 1'b1 || a_clk_en !== 1'b1) begin errors++; $display("FAIL b2b_wait frame=%0d cyc=%0d got busy=%b en=%b exp busy=1 en=1", f, w, busy, a_clk_en); end
                @(negedge clk);
            end
            checks++; if (busy !== 1'b0 || a_clk_en !== 1'b1 || in_ready !== 1'b1) begin errors++; $display("FAIL b2b_gap frame=%0d got busy=%b en=%b ready=%b exp 0 1 1", f, busy, a_clk_en, in_ready); end
            if (f == 0) b_done = 1'b0;
            $display("back-to-back frame=%0d data=%h gray=%h", f, d, exp[DW-1:0]);
            @(negedge clk);
        end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL b2b_end got busy=%b exp=0", busy); end
    endtask

    task automatic test_random();
        for (int n = 0; n < 25; n++) begin
            run_frame(DW'($urandom), 1'b1, $urandom_range(1, TO + 2), 1'b1);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_ack_latency();
        test_stuck_high();
        test_boundary();
        test_mid_reset();
        test_back_to_back();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
